// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo_pkg
//  Brief    : Shared defaults and sizing helpers for the parametrised FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
package sync_fifo_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_ADDR_W = 4;
  localparam int DEFAULT_CNT_W  = DEFAULT_ADDR_W + 1;

  // Number of words addressed by an addr_w-bit pointer.
  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  // Occupancy counter needs one extra bit to represent a completely full FIFO.
  function automatic int count_width(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_mem_2p.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_mem_2p
//  Brief    : DEPTH x DATA_W register array, synchronous write port and
//             asynchronous read port. Contents are deliberately not reset.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_mem_2p
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = fifo_depth(ADDR_W);

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  // Write port: store one word per accepted write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo_param
//  Brief    : Parametrised single-clock FIFO with standard or FWFT read mode,
//             programmable almost flags, sticky error flags and flush.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = fifo_depth(ADDR_W) - 2,
  parameter int AE_THRESH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              w_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              r_en,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int               DEPTH   = fifo_depth(ADDR_W);
  localparam int               CNT_W   = count_width(ADDR_W);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              wr_acc;
  logic              rd_acc;

  // Status flags derive only from the registered count, so they never
  // glitch with the request inputs.
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // A write is refused when full even if a read frees a slot this cycle.
  assign wr_acc = w_en & ~full & ~clr;
  assign rd_acc = r_en & ~empty & ~clr;

  fifo_mem_2p #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (w_addr),
    .wdata (data_in),
    .raddr (r_addr),
    .rdata (mem_rdata)
  );

  // Pointers, occupancy and sticky error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_addr    <= '0;
      r_addr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      w_addr    <= '0;
      r_addr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        w_addr <= w_addr + ADDR_W'(1);
      end
      if (rd_acc) begin
        r_addr <= r_addr + ADDR_W'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (w_en && full) begin
        overflow <= 1'b1;
      end
      if (r_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented directly from the array while data exists.
      assign data_out = empty ? '0 : mem_rdata;
      assign rd_valid = ~empty;
    end else begin : g_std
      logic [DATA_W-1:0] data_q;
      logic              valid_q;

      // Registered read: capture the head word on each accepted read.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          data_q  <= '0;
          valid_q <= 1'b0;
        end else if (clr) begin
          data_q  <= '0;
          valid_q <= 1'b0;
        end else if (rd_acc) begin
          data_q  <= mem_rdata;
          valid_q <= 1'b1;
        end else begin
          valid_q <= 1'b0;
        end
      end

      assign data_out = data_q;
      assign rd_valid = valid_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sync_fifo_param
//  Brief    : Self-checking bench for sync_fifo_param: a 16-deep standard
//             instance and a 4-deep FWFT instance, each with a queue model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_param;

  logic clk;
  logic rst;

  // Standard-mode instance (defaults: 16 words, AF=14, AE=2).
  logic       s_clr, s_wen, s_ren;
  logic [7:0] s_din, s_dout;
  logic [4:0] s_cnt;
  logic       s_vld, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;

  // FWFT instance (4 words, AF=2, AE=2).
  logic       f_clr, f_wen, f_ren;
  logic [7:0] f_din, f_dout;
  logic [2:0] f_cnt;
  logic       f_vld, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;

  int checks = 0;
  int errors = 0;

  logic [7:0] s_q[$];
  logic [7:0] f_q[$];
  logic [7:0] s_m_dout = 8'h00;
  logic       s_m_ovf = 1'b0, s_m_udf = 1'b0;
  logic       f_m_ovf = 1'b0, f_m_udf = 1'b0;

  sync_fifo_param #(.DATA_W(8), .ADDR_W(4), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .clr(s_clr), .w_en(s_wen), .data_in(s_din),
    .r_en(s_ren), .data_out(s_dout), .rd_valid(s_vld), .count(s_cnt),
    .full(s_full), .empty(s_empty), .almost_full(s_af),
    .almost_empty(s_ae), .overflow(s_ovf), .underflow(s_udf)
  );

  sync_fifo_param #(.DATA_W(8), .ADDR_W(2), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .clr(f_clr), .w_en(f_wen), .data_in(f_din),
    .r_en(f_ren), .data_out(f_dout), .rd_valid(f_vld), .count(f_cnt),
    .full(f_full), .empty(f_empty), .almost_full(f_af),
    .almost_empty(f_ae), .overflow(f_ovf), .underflow(f_udf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic s_flags(input logic exp_vld);
    int n;
    n = s_q.size();
    check("s_count", 32'(s_cnt), 32'(n));
    check("s_full", 32'(s_full), 32'(n == 16));
    check("s_empty", 32'(s_empty), 32'(n == 0));
    check("s_almost_full", 32'(s_af), 32'(n >= 14));
    check("s_almost_empty", 32'(s_ae), 32'(n <= 2));
    check("s_overflow", 32'(s_ovf), 32'(s_m_ovf));
    check("s_underflow", 32'(s_udf), 32'(s_m_udf));
    check("s_rd_valid", 32'(s_vld), 32'(exp_vld));
    check("s_data_out", 32'(s_dout), 32'(s_m_dout));
  endtask

  task automatic f_flags();
    int n;
    n = f_q.size();
    check("f_count", 32'(f_cnt), 32'(n));
    check("f_full", 32'(f_full), 32'(n == 4));
    check("f_empty", 32'(f_empty), 32'(n == 0));
    check("f_almost_full", 32'(f_af), 32'(n >= 2));
    check("f_almost_empty", 32'(f_ae), 32'(n <= 2));
    check("f_overflow", 32'(f_ovf), 32'(f_m_ovf));
    check("f_underflow", 32'(f_udf), 32'(f_m_udf));
    check("f_rd_valid", 32'(f_vld), 32'(n != 0));
    check("f_data_out", 32'(f_dout), (n != 0) ? 32'(f_q[0]) : 32'h0);
  endtask

  // One clock of stimulus on the standard instance, then score the result.
  task automatic s_cycle(input logic w, input logic [7:0] d, input logic r, input logic c);
    logic wacc, racc;
    wacc = w && (s_q.size() != 16) && !c;
    racc = r && (s_q.size() != 0) && !c;
    s_wen = w; s_din = d; s_ren = r; s_clr = c;
    @(posedge clk);
    #1;
    s_wen = 1'b0; s_ren = 1'b0; s_clr = 1'b0;
    if (c) begin
      s_q.delete();
      s_m_ovf = 1'b0; s_m_udf = 1'b0; s_m_dout = 8'h00;
    end else begin
      if (w && s_q.size() == 16) s_m_ovf = 1'b1;
      if (r && s_q.size() == 0) s_m_udf = 1'b1;
      if (racc) s_m_dout = s_q.pop_front();
      if (wacc) s_q.push_back(d);
    end
    s_flags(racc);
  endtask

  // One clock of stimulus on the FWFT instance, then score the result.
  task automatic f_cycle(input logic w, input logic [7:0] d, input logic r, input logic c);
    logic wacc, racc;
    wacc = w && (f_q.size() != 4) && !c;
    racc = r && (f_q.size() != 0) && !c;
    f_wen = w; f_din = d; f_ren = r; f_clr = c;
    @(posedge clk);
    #1;
    f_wen = 1'b0; f_ren = 1'b0; f_clr = 1'b0;
    if (c) begin
      f_q.delete();
      f_m_ovf = 1'b0; f_m_udf = 1'b0;
    end else begin
      if (w && f_q.size() == 4) f_m_ovf = 1'b1;
      if (r && f_q.size() == 0) f_m_udf = 1'b1;
      if (racc) void'(f_q.pop_front());
      if (wacc) f_q.push_back(d);
    end
    f_flags();
  endtask

  initial begin
    rst = 1'b0;
    s_clr = 1'b0; s_wen = 1'b0; s_ren = 1'b0; s_din = 8'h00;
    f_clr = 1'b0; f_wen = 1'b0; f_ren = 1'b0; f_din = 8'h00;
    #2;
    s_flags(1'b0);
    f_flags();
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Fill to full, overflow attempt, drain in order.
    for (int i = 1; i <= 16; i++) s_cycle(1'b1, 8'(i), 1'b0, 1'b0);
    s_cycle(1'b1, 8'h11, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) s_cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Underflow on empty, then flush clears it.
    s_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    s_cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // Simultaneous read/write at count 5 and at full.
    for (int i = 0; i < 5; i++) s_cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) s_cycle(1'b1, 8'(8'h30 + i), 1'b1, 1'b0);
    for (int i = 0; i < 11; i++) s_cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    s_cycle(1'b1, 8'hEE, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) s_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    s_cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // Flush overrides a same-cycle write.
    for (int i = 0; i < 7; i++) s_cycle(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    s_cycle(1'b1, 8'h99, 1'b0, 1'b1);
    s_cycle(1'b1, 8'h77, 1'b0, 1'b0);
    s_cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // FWFT: single word visible the cycle after its write, then popped.
    f_cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    f_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    // FWFT wrap with occupancy held at 3 over 11 words.
    for (int i = 0; i < 3; i++) f_cycle(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0);
    for (int i = 3; i < 11; i++) f_cycle(1'b1, 8'(8'hB0 + i), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) f_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    // FWFT overflow / underflow and flush.
    for (int i = 0; i < 5; i++) f_cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) f_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    f_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    f_cycle(1'b1, 8'hD1, 1'b0, 1'b0);

    // Asynchronous reset in mid-cycle while read data is valid.
    for (int i = 0; i < 3; i++) s_cycle(1'b1, 8'(8'h61 + i), 1'b0, 1'b0);
    s_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    #3;
    rst = 1'b0;
    #1;
    s_q.delete(); f_q.delete();
    s_m_ovf = 1'b0; s_m_udf = 1'b0; s_m_dout = 8'h00;
    f_m_ovf = 1'b0; f_m_udf = 1'b0;
    s_flags(1'b0);
    f_flags();
    @(posedge clk);
    #1;
    rst = 1'b1;
    s_cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    s_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    f_cycle(1'b1, 8'h3C, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO, successor to the team's fixed-size sync FIFO. It adds the following over that block:
- Power-of-two depth set by ADDR_W.
- Selectable standard or first-word-fall-through (FWFT) read mode.
- Programmable almost-full and almost-empty flags.
- Sticky overflow and underflow error flags.
- Synchronous flush.

It sits between producer and consumer datapaths in one clock domain.

Parameters:
DATA_W, 8, data word width in bits (>=1)
ADDR_W, 4, pointer width; DEPTH = 2**ADDR_W words (ADDR_W >= 1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1)

Ports:
clk  in  1  clock, all state changes on rising edge
rst  in  1  asynchronous active-low reset
clr  in  1  synchronous flush, active high
w_en  in  1  write request
data_in  in  DATA_W  write data
r_en  in  1  read request (pop in FWFT mode)
data_out  out  DATA_W  read data
rd_valid  out  1  data_out holds valid read data
count  out  ADDR_W+1  words stored, 0..DEPTH
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty

Behaviour:
Reset (rst=0, asynchronous):
- w_addr, r_addr, count, data_out, rd_valid, overflow and underflow all go to 0.
- Consequently empty=1, almost_empty=1, full=0, almost_full=0.
- Memory array is not reset.

Accept conditions:
- wr_acc = w_en & ~full & ~clr.
- rd_acc = r_en & ~empty & ~clr.
- A write is rejected when full even if a read is accepted in the same cycle.

Memory and pointers:
- wr_acc writes mem[w_addr] <= data_in; w_addr increments.
- rd_acc increments r_addr.
- Both pointers wrap naturally modulo DEPTH.

Count:
- +1 on wr_acc & ~rd_acc.
- -1 on rd_acc & ~wr_acc.
- Unchanged when both or neither occur.
- Never leaves 0..DEPTH.

Flags:
- full, empty, almost_full and almost_empty are combinational from the registered count.
- No glitch from w_en or r_en.

Standard mode (FWFT=0):
- rd_acc at edge N: data_out = mem[r_addr] after edge N; rd_valid=1 for exactly that cycle.
- Otherwise rd_valid=0 and data_out holds its last value.

FWFT mode (FWFT=1):
- data_out = mem[r_addr] combinationally when ~empty, else 0.
- rd_valid = ~empty.
- rd_acc consumes the word shown.
- A word written at edge N into an empty FIFO appears on data_out with rd_valid=1 in the cycle after edge N (no same-cycle bypass).

Sticky error flags:
- overflow sets on w_en & full & ~clr.
- underflow sets on r_en & empty & ~clr.
- Both stay set until rst or clr.
- The rejected operation changes no other state.

Flush (clr=1 at an edge):
- Pointers, count, overflow, underflow and rd_valid go to 0; standard-mode data_out goes to 0.
- clr overrides w_en and r_en in the same cycle.
- Memory contents are retained but unreachable.

Reset asserted mid-operation discards all contents; the first write after release lands at address 0.

Decomposition:
- Shared package sync_fifo_pkg holds:
  - default DATA_W and ADDR_W;
  - a depth function (2**ADDR_W);
  - the count-width constant ADDR_W+1.
- One sub-module, fifo_mem_2p: DEPTH x DATA_W register array with synchronous write port and asynchronous read port.
  - The top level holds pointers, count, flags and output staging.

Test Plan:
1. Defaults, FWFT=0: write 0x01..0x10 (16 words) -> full=1 and count=16 after the 16th edge; almost_full first asserts at count=14. A 17th write sets overflow=1 with count still 16. Reading 16 words returns 0x01..0x10 in order, each with rd_valid high one cycle after its r_en.
2. Empty FIFO: pulse r_en -> underflow=1, count=0, rd_valid=0, data_out unchanged. Then pulse clr -> underflow=0.
3. Count=5: assert w_en and r_en together for 4 cycles -> count stays 5 and data order is preserved. Repeat at count=16: read accepted, write rejected, count becomes 15, overflow=1.
4. FWFT=1: write 0xA5 into empty at edge N -> data_out=0xA5 and rd_valid=1 in cycle N+1. Pop -> empty=1, data_out=0.
5. Wrap: ADDR_W=2; push/pop 11 words with occupancy held at 3 -> output sequence matches input and pointers wrap without loss.
6. With count=7, assert clr together with w_en -> count=0, empty=1, and the write is dropped. Separately, pull rst low mid-cycle -> all outputs go to reset values immediately, without waiting for a clock edge.
